// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: default datapath width, opcode constants and the
// prefetch entry layout carried from fetch to decode.
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] OP_BEQZ  = 6'h34;
  localparam logic [5:0] OP_BNEQZ = 6'h35;
  localparam logic [5:0] OP_LD    = 6'h30;
  localparam logic [5:0] OP_ST    = 6'h31;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] ir;
    logic [XLEN_DEFAULT-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_queue_if.sv
// Fetch-stage bus: branch/halt controls, instruction-memory port and the
// decode-side valid/ready handshake.
interface mips_fetch_queue_if
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = 10
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_ir;
  logic [XLEN-1:0] out_npc;

  modport master (
    input  redirect_valid, redirect_pc, halt, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_ir, out_npc
  );

  modport slave (
    output redirect_valid, redirect_pc, halt, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_ir, out_npc
  );
endinterface

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with flush, simultaneous push/pop and occupancy count.
// The head reads as zero while the FIFO is empty.
module mips_sync_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH = 2 * XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against occupancy and select the head word.
  always_comb begin
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
    push_ok_s = push && ((count_r < CW'(DEPTH)) || pop_ok_s);
    if (count_r != {CW{1'b0}}) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = {WIDTH{1'b0}};
    end
  end

  assign count = count_r;

  // Entry storage; stale words are harmless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush wins over any push in that cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/mips_fetch_queue.sv
// Prefetching MIPS32 fetch stage: PC, epoch, in-flight and halt tracking plus
// the credit-based issue rule feeding a prefetch queue that decode drains.
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              AW       = 10,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input logic               clk,
  input logic               rst,
  mips_fetch_queue_if.master bus
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0]   pc_r;
  logic              inflight_r;
  logic [XLEN-1:0]   inflight_npc_r;
  logic              inflight_epoch_r;
  logic              epoch_r;
  logic              halted_r;
  logic [CW-1:0]     count_s;
  logic [2*XLEN-1:0] head_s;
  logic [CW:0]       occupancy_s;
  logic              out_valid_s;
  logic              pop_s;
  logic              push_s;
  logic              req_s;

  // In-flight requests hold a queue slot, so the queue can never overflow.
  always_comb begin
    out_valid_s = (count_s != {CW{1'b0}});
    pop_s       = out_valid_s && bus.out_ready;
    occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    req_s       = !rst && !halted_r && !bus.halt && !bus.redirect_valid &&
                  (occupancy_s < (CW + 1)'(QDEPTH));
    push_s      = inflight_r && (inflight_epoch_r == epoch_r) && !bus.redirect_valid;
  end

  // PC, epoch, halt and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r             <= RESET_PC;
      inflight_r       <= 1'b0;
      inflight_npc_r   <= {XLEN{1'b0}};
      inflight_epoch_r <= 1'b0;
      epoch_r          <= 1'b0;
      halted_r         <= 1'b0;
    end else begin
      if (bus.halt) begin
        halted_r <= 1'b1;
      end
      if (bus.redirect_valid) begin
        pc_r    <= bus.redirect_pc;
        epoch_r <= ~epoch_r;
      end else if (req_s) begin
        pc_r <= pc_r + XLEN'(1);
      end
      inflight_r <= req_s;
      if (req_s) begin
        inflight_npc_r   <= pc_r + XLEN'(1);
        inflight_epoch_r <= epoch_r;
      end
    end
  end

  mips_sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push_s),
    .push_data ({bus.imem_rdata, inflight_npc_r}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign bus.imem_req  = req_s;
  assign bus.imem_addr = pc_r[AW-1:0];
  assign bus.out_valid = out_valid_s;
  assign bus.out_ir    = head_s[2*XLEN-1:XLEN];
  assign bus.out_npc   = head_s[XLEN-1:0];
endmodule
